// File: rtl/fpu_add_subt_issuer.sv
// fpu_add_subt_issuer: initiator side of the FPU add/subtract controller
// handshake (beg_FSM / ready / rst_FSM). Takes one operation at a time from a
// host valid/ready port, starts the controller, waits for ready, captures the
// result, releases the controller back to its start state and hands the result
// back to the host. A watchdog aborts hung operations and pulses fpu_rst_o.
// Optional build macro FPU_ISSUER_STATS_EN adds saturating completion and
// timeout counters (stat_done_o / stat_timeout_o).
module fpu_add_subt_issuer #(
  parameter int W              = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7,
  parameter int RST_PULSE      = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid_i,
  output logic         op_ready_o,
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  input  logic         op_sub_i,
  output logic [W-1:0] data_x_o,
  output logic [W-1:0] data_y_o,
  output logic         add_subt_o,
  output logic         beg_FSM_o,
  output logic         rst_FSM_o,
  output logic         fpu_rst_o,
  input  logic         ready_i,
  input  logic [W-1:0] fpu_result_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [W-1:0] res_data_o,
  output logic         res_timeout_o
`ifdef FPU_ISSUER_STATS_EN
  ,
  output logic [15:0]  stat_done_o,
  output logic [15:0]  stat_timeout_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RELEASE,
    S_ABORT,
    S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] WD_MAX     = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wdog;
  logic             timeout_hit;
  logic             pulse_done;

  assign timeout_hit = (wdog == WD_LAST);
  assign pulse_done  = (wdog == PULSE_LAST);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before this edge.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the state-decoded handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_nxt   = state;
    op_ready_o  = 1'b0;
    beg_FSM_o   = 1'b0;
    rst_FSM_o   = 1'b0;
    fpu_rst_o   = 1'b0;
    res_valid_o = 1'b0;
    case (state)
      S_IDLE: begin
        // Held low during rst so every output reads 0 while in reset.
        op_ready_o = !rst;
        if (op_valid_i) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        beg_FSM_o = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A ready arriving on the final watchdog cycle still counts as done.
        if (ready_i)          state_nxt = S_RELEASE;
        else if (timeout_hit) state_nxt = S_ABORT;
      end
      S_RELEASE: begin
        // Keep pushing the controller back to start until it drops ready.
        rst_FSM_o = ready_i;
        if (!ready_i) state_nxt = S_RESP;
      end
      S_ABORT: begin
        fpu_rst_o = 1'b1;
        if (pulse_done) state_nxt = S_RESP;
      end
      S_RESP: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Watchdog: counts WAIT cycles, then reused to time the abort reset pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog <= '0;
    end else begin
      case (state)
        S_ISSUE: wdog <= '0;
        S_WAIT: begin
          if (!ready_i && timeout_hit) wdog <= '0;
          else if (wdog != WD_MAX)     wdog <= wdog + 1'b1;
        end
        S_ABORT: if (wdog != WD_MAX) wdog <= wdog + 1'b1;
        default: wdog <= wdog;
      endcase
    end
  end

  // Operand latch on accept and result capture on completion or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_x_o      <= '0;
      data_y_o      <= '0;
      add_subt_o    <= 1'b0;
      res_data_o    <= '0;
      res_timeout_o <= 1'b0;
    end else begin
      if (state == S_IDLE && op_valid_i) begin
        data_x_o   <= op_a_i;
        data_y_o   <= op_b_i;
        add_subt_o <= op_sub_i;
      end
      if (state == S_WAIT) begin
        if (ready_i) begin
          res_data_o    <= fpu_result_i;
          res_timeout_o <= 1'b0;
        end else if (timeout_hit) begin
          res_data_o    <= '0;
          res_timeout_o <= 1'b1;
        end
      end
    end
  end

`ifdef FPU_ISSUER_STATS_EN
  // Saturating counters of results handed to the host, split by outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_done_o    <= '0;
      stat_timeout_o <= '0;
    end else if (state == S_RESP && res_ready_i) begin
      if (res_timeout_o) begin
        if (stat_timeout_o != 16'hFFFF) stat_timeout_o <= stat_timeout_o + 16'd1;
      end else begin
        if (stat_done_o != 16'hFFFF) stat_done_o <= stat_done_o + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
